i2c_master_write_byte: RTL and testbench
========================================

I2C_MASTER_WRITE_BYTE -- requirements
Module: i2c_master_write_byte

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1: 1 = data bit 7 is sent first; 0 = bit 0 is sent first.
REQ-002 SHALL have port clock, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port go, input, 1, byte request, sampled only while the block is idle.
REQ-005 SHALL have port data, input, 8, byte to transmit, latched on accept.
REQ-006 SHALL have port with_start, input, 1, prepend a START_BIT command, latched on accept.
REQ-007 SHALL have port with_stop, input, 1, append a STOP_BIT command, latched on accept.
REQ-008 SHALL have port busy, output, 1, high from the cycle after accept until finish.
REQ-009 SHALL have port finish, output, 1, one-cycle pulse when the byte sequence completes.
REQ-010 SHALL have port bit_go, output, 1, request to the downstream I2C_master_write_bit.
REQ-011 SHALL have port bit_command, output, 3, command to the bit writer.
REQ-012 SHALL have port bit_finish, input, 1, completion pulse from the bit writer.

Function
REQ-013 SHALL use these command encodings: IDLE 000, START_BIT 010, STOP_BIT 011, DATA_0 100, DATA_1 101.
REQ-014 SHALL have FSM states IDLE, START, DATA, STOP, DONE.
REQ-015 SHALL, in IDLE with go=1 at a clock edge, latch data/with_start/with_stop and enter START if with_start=1, else DATA.
REQ-016 SHALL, in the first cycle after accept, have busy=1 and bit_go=1, with bit_command equal to the first command.
REQ-017 SHALL hold bit_go=1 and bit_command stable in START, DATA and STOP until bit_finish=1 is sampled.
REQ-018 SHALL, on bit_finish in START, enter DATA with bit counter=0.
REQ-019 SHALL, in DATA, drive DATA_1 when the current bit is 1 and DATA_0 when it is 0, taking bits from a shift register in the MSB_FIRST order.
REQ-020 SHALL, on bit_finish in DATA, shift the register and increment a 3-bit counter; on bit_finish with counter=7, enter STOP if with_stop=1, else DONE.
REQ-021 SHALL, on bit_finish in STOP, enter DONE.
REQ-022 SHALL, in DONE, assert finish=1 for exactly one cycle with busy=0, bit_go=0, bit_command=IDLE, then return to IDLE.
REQ-023 SHALL set bit_go=0 and bit_command=IDLE in IDLE and DONE.
REQ-024 SHALL ignore go while busy; changes on data/with_* while busy SHALL NOT affect the sequence in progress.
REQ-025 SHALL ignore bit_finish in IDLE and DONE.
REQ-026 SHALL accept go on the cycle immediately after DONE, giving back-to-back bytes with one idle cycle of bit_go=0.
REQ-027 SHALL issue exactly 8 + with_start + with_stop commands per accepted byte, each consumed by exactly one bit_finish.

Reset
REQ-028 SHALL, while reset=1, asynchronously force state=IDLE, counter=0, shift register=0, latched flags=0, busy=0, finish=0, bit_go=0, bit_command=IDLE.
REQ-029 SHALL, on reset mid-sequence, drop bit_go in the same cycle, emit no finish pulse, and require a new go after reset is released.

Structure
REQ-030 SHALL take the command encodings and the FSM state encoding from shared package i2c_pkg, which I2C_master_write_bit also uses.
REQ-031 SHALL need no sub-module; the parent instantiates this block directly upstream of I2C_master_write_bit, wiring bit_go->go, bit_command->command and finish->bit_finish.

Verification
REQ-032 SHALL cover: data=8'hA5, with_start=1, with_stop=1, MSB_FIRST=1, bit writer model finish after 4 cycles -> commands START, 101,100,101,100,100,101,100,101, STOP, then one finish pulse.
REQ-033 SHALL cover: data=8'h01, with_start=0, with_stop=0, MSB_FIRST=0 -> first command DATA_1, then seven DATA_0, exactly 8 commands, then finish.
REQ-034 SHALL cover: go pulsed and data changed to 8'hFF during the third data bit of byte 8'h00 -> all eight commands are DATA_0 and there is one finish only.
REQ-035 SHALL cover: reset asserted during the fifth data bit -> same-cycle bit_go=0, bit_command=000, busy=0, and no finish pulse.
REQ-036 SHALL cover: go held high continuously across two bytes -> second byte accepted the cycle after finish, with one cycle of bit_go=0 between bytes.
REQ-037 SHALL cover: bit_finish pulsed while IDLE -> no state change and all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C bit-writer command codes and byte-writer FSM states.
// Used by both the byte writer and the downstream bit writer.
package i2c_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE   = 3'b000,
    CMD_START  = 3'b010,
    CMD_STOP   = 3'b011,
    CMD_DATA_0 = 3'b100,
    CMD_DATA_1 = 3'b101
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  function automatic cmd_t data_cmd(input logic b);
    return b ? CMD_DATA_1 : CMD_DATA_0;
  endfunction

endpackage

// File: rtl/i2c_master_write_byte_if.sv
// Byte request / bit-writer handshake bundle for the I2C byte writer.
// master = requester side, slave = the byte writer itself.
interface i2c_master_write_byte_if;

  logic       go;
  logic [7:0] data;
  logic       with_start;
  logic       with_stop;
  logic       busy;
  logic       finish;
  logic       bit_go;
  logic [2:0] bit_command;
  logic       bit_finish;

  modport master (
    output go, data, with_start, with_stop, bit_finish,
    input  busy, finish, bit_go, bit_command
  );

  modport slave (
    input  go, data, with_start, with_stop, bit_finish,
    output busy, finish, bit_go, bit_command
  );

endinterface

// File: rtl/i2c_master_write_byte.sv
// Sequences one byte (optional START/STOP) into per-bit commands
// for the downstream I2C bit writer.
module i2c_master_write_byte
  import i2c_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                    clock,
  input logic                    reset,
  i2c_master_write_byte_if.slave bus
);

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] shreg;
  logic       stop_en;
  logic [7:0] next_sh;

  function automatic logic cur_bit(input logic [7:0] s);
    return MSB_FIRST ? s[7] : s[0];
  endfunction

  assign next_sh = MSB_FIRST ? {shreg[6:0], 1'b0}
                             : {1'b0, shreg[7:1]};

  // DONE behaves like IDLE for a new request, so a held go
  // restarts right after the finish pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= 3'd0;
      shreg           <= 8'd0;
      stop_en         <= 1'b0;
      bus.busy        <= 1'b0;
      bus.finish      <= 1'b0;
      bus.bit_go      <= 1'b0;
      bus.bit_command <= CMD_IDLE;
    end else begin
      bus.finish <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.go) begin
            shreg      <= bus.data;
            stop_en    <= bus.with_stop;
            cnt        <= 3'd0;
            bus.busy   <= 1'b1;
            bus.bit_go <= 1'b1;
            if (bus.with_start) begin
              state           <= S_START;
              bus.bit_command <= CMD_START;
            end else begin
              state           <= S_DATA;
              bus.bit_command <= data_cmd(cur_bit(bus.data));
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_START: begin
          if (bus.bit_finish) begin
            state           <= S_DATA;
            cnt             <= 3'd0;
            bus.bit_command <= data_cmd(cur_bit(shreg));
          end
        end
        S_DATA: begin
          if (bus.bit_finish) begin
            shreg <= next_sh;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (stop_en) begin
                state           <= S_STOP;
                bus.bit_command <= CMD_STOP;
              end else begin
                state           <= S_DONE;
                bus.busy        <= 1'b0;
                bus.bit_go      <= 1'b0;
                bus.bit_command <= CMD_IDLE;
                bus.finish      <= 1'b1;
              end
            end else begin
              bus.bit_command <= data_cmd(cur_bit(next_sh));
            end
          end
        end
        S_STOP: begin
          if (bus.bit_finish) begin
            state           <= S_DONE;
            bus.busy        <= 1'b0;
            bus.bit_go      <= 1'b0;
            bus.bit_command <= CMD_IDLE;
            bus.finish      <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_write_byte.sv
// Scoreboard bench for the I2C byte writer with a 4-cycle bit-writer model.
// Two instances cover MSB-first and LSB-first ordering.
module tb_i2c_master_write_byte;

  localparam logic [2:0] C_IDLE = 3'b000;
  localparam logic [2:0] C_ST   = 3'b010;
  localparam logic [2:0] C_SP   = 3'b011;
  localparam logic [2:0] C_D0   = 3'b100;
  localparam logic [2:0] C_D1   = 3'b101;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic inj   = 1'b0;
  logic mf_m  = 1'b0;
  logic mf_l  = 1'b0;

  int cnt_m = 0;
  int cnt_l = 0;
  int checks = 0;
  int failures = 0;
  int seen_m = 0;
  int seen_l = 0;
  int exp_fin_m = 0;
  int exp_fin_l = 0;
  int base;

  logic [2:0] exp_m[$];
  logic [2:0] exp_l[$];
  logic       prev_m = 1'b0;
  logic       prev_l = 1'b0;
  logic [2:0] pcmd_m = 3'b0;
  logic [2:0] pcmd_l = 3'b0;

  i2c_master_write_byte_if bm();
  i2c_master_write_byte_if bl();

  assign bm.bit_finish = mf_m | inj;
  assign bl.bit_finish = mf_l;

  i2c_master_write_byte #(.MSB_FIRST(1'b1)) u_msb (
    .clock(clock),
    .reset(reset),
    .bus  (bm.slave)
  );

  i2c_master_write_byte #(.MSB_FIRST(1'b0)) u_lsb (
    .clock(clock),
    .reset(reset),
    .bus  (bl.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  // bit-writer models: finish pulse after 4 cycles of bit_go
  initial forever begin
    @(posedge clock);
    #1;
    if (reset || mf_m) begin
      mf_m = 1'b0;
      cnt_m = 0;
    end else if (bm.bit_go) begin
      cnt_m++;
      if (cnt_m == 4) mf_m = 1'b1;
    end else cnt_m = 0;
    if (reset || mf_l) begin
      mf_l = 1'b0;
      cnt_l = 0;
    end else if (bl.bit_go) begin
      cnt_l++;
      if (cnt_l == 4) mf_l = 1'b1;
    end else cnt_l = 0;
  end

  // monitor: pops expected commands / finish pulses
  initial forever begin
    @(negedge clock);
    if (reset) begin
      prev_m = 1'b0;
      prev_l = 1'b0;
    end else begin
      if (prev_m) chk("hold_m", {bm.bit_go, bm.bit_command}, {1'b1, pcmd_m});
      if (bm.bit_go && bm.bit_finish) begin
        seen_m++;
        if (exp_m.size() == 0) mon_fail("extra_cmd_m");
        else chk("cmd_m", bm.bit_command, exp_m.pop_front());
      end
      if (bm.finish) begin
        if (exp_fin_m == 0) mon_fail("extra_finish_m");
        else exp_fin_m--;
        chk("done_out_m", {bm.busy, bm.bit_go, bm.bit_command}, 0);
      end
      prev_m = bm.bit_go && !bm.bit_finish;
      pcmd_m = bm.bit_command;

      if (prev_l) chk("hold_l", {bl.bit_go, bl.bit_command}, {1'b1, pcmd_l});
      if (bl.bit_go && bl.bit_finish) begin
        seen_l++;
        if (exp_l.size() == 0) mon_fail("extra_cmd_l");
        else chk("cmd_l", bl.bit_command, exp_l.pop_front());
      end
      if (bl.finish) begin
        if (exp_fin_l == 0) mon_fail("extra_finish_l");
        else exp_fin_l--;
        chk("done_out_l", {bl.busy, bl.bit_go, bl.bit_command}, 0);
      end
      prev_l = bl.bit_go && !bl.bit_finish;
      pcmd_l = bl.bit_command;
    end
  end

  task automatic push(input bit lsb, input int n, input logic [29:0] seq);
    for (int i = 0; i < n; i++) begin
      if (lsb) exp_l.push_back(seq[29-3*i -: 3]);
      else exp_m.push_back(seq[29-3*i -: 3]);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      if (exp_fin_m == 0 && exp_fin_l == 0 &&
          exp_m.size() == 0 && exp_l.size() == 0) break;
      step();
    end
    chk({name, "_drain"},
        exp_fin_m + exp_fin_l + exp_m.size() + exp_l.size(), 0);
  endtask

  task automatic wait_seen_m(input int target);
    for (int i = 0; i < 200; i++) begin
      if (seen_m >= target) break;
      step();
    end
    chk("seen_m", seen_m >= target, 1);
  endtask

  initial begin
    bm.go = 0; bm.data = 0; bm.with_start = 0; bm.with_stop = 0;
    bl.go = 0; bl.data = 0; bl.with_start = 0; bl.with_stop = 0;
    repeat (2) step();
    chk("rst_busy", bm.busy, 0);
    chk("rst_bit_go", bm.bit_go, 0);
    chk("rst_cmd", bm.bit_command, C_IDLE);
    chk("rst_finish", bm.finish, 0);
    chk("rst_lsb", {bl.busy, bl.bit_go, bl.bit_command, bl.finish}, 0);
    reset = 0;
    step();

    // A5 with start and stop, MSB first
    push(0, 10, {C_ST, C_D1, C_D0, C_D1, C_D0, C_D0, C_D1, C_D0, C_D1, C_SP});
    exp_fin_m = 1;
    bm.data = 8'hA5; bm.with_start = 1; bm.with_stop = 1; bm.go = 1;
    step();
    bm.go = 0;
    chk("first_busy", bm.busy, 1);
    chk("first_bit_go", bm.bit_go, 1);
    chk("first_cmd", bm.bit_command, C_ST);
    wait_idle("a5");

    // 01, no start/stop, LSB first
    push(1, 8, {C_D1, {7{C_D0}}, 6'b0});
    exp_fin_l = 1;
    bl.data = 8'h01; bl.with_start = 0; bl.with_stop = 0; bl.go = 1;
    step();
    bl.go = 0;
    chk("lsb_first_cmd", bl.bit_command, C_D1);
    wait_idle("lsb01");

    // 00 with go/data disturbed during third data bit
    push(0, 8, {{8{C_D0}}, 6'b0});
    exp_fin_m = 1;
    base = seen_m;
    bm.data = 8'h00; bm.with_start = 0; bm.with_stop = 0; bm.go = 1;
    step();
    bm.go = 0;
    wait_seen_m(base + 2);
    bm.data = 8'hFF; bm.with_start = 1; bm.with_stop = 1; bm.go = 1;
    repeat (3) step();
    chk("busy_during", bm.busy, 1);
    bm.go = 0;
    wait_idle("hold00");

    // reset during fifth data bit
    push(0, 10, {C_ST, C_D1, C_D0, C_D1, C_D0, C_D0, C_D1, C_D0, C_D1, C_SP});
    exp_fin_m = 1;
    base = seen_m;
    bm.data = 8'hA5; bm.with_start = 1; bm.with_stop = 1; bm.go = 1;
    step();
    bm.go = 0;
    wait_seen_m(base + 5);
    step();
    chk("bit5_cmd", bm.bit_command, C_D0);
    #1 reset = 1;
    #1;
    chk("rst_mid_bit_go", bm.bit_go, 0);
    chk("rst_mid_cmd", bm.bit_command, C_IDLE);
    chk("rst_mid_busy", bm.busy, 0);
    chk("rst_mid_finish", bm.finish, 0);
    exp_m.delete();
    exp_fin_m = 0;
    step();
    reset = 0;
    repeat (10) step();
    chk("post_rst_bit_go", bm.bit_go, 0);
    chk("post_rst_busy", bm.busy, 0);

    // go held high across two bytes
    repeat (2) push(0, 9, {C_D0, C_D0, C_D1, C_D1, C_D1, C_D1, C_D0, C_D0, C_SP, 3'b0});
    exp_fin_m = 2;
    bm.data = 8'h3C; bm.with_start = 0; bm.with_stop = 1; bm.go = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (bm.finish) break;
    end
    chk("b2b_finish", bm.finish, 1);
    step();
    chk("b2b_bit_go", bm.bit_go, 1);
    chk("b2b_busy", bm.busy, 1);
    chk("b2b_cmd", bm.bit_command, C_D0);
    bm.go = 0;
    wait_idle("b2b");

    // bit_finish pulsed while idle
    step();
    inj = 1;
    step();
    inj = 0;
    repeat (3) begin
      step();
      chk("idle_out", {bm.busy, bm.finish, bm.bit_go, bm.bit_command}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
